// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit: PC holder, in-order instruction memory fetch, DEPTH-entry
// instruction buffer with valid/ready toward decode and branch redirect flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_IMemReq,
   output logic [31:0] o_IMemAddr,
   input  logic        i_IMemGnt,
   input  logic        i_IMemRValid,
   input  logic [31:0] i_IMemRData,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectPC,
   output logic        o_InstrValid,
   output logic [31:0] o_Instr,
   output logic [31:0] o_InstrPC,
   output logic [6:0]  o_OPCode,
   input  logic        i_InstrReady
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]      instr_mem_q [DEPTH];
   logic [31:0]      pc_mem_q    [DEPTH];

   logic [CNT_W:0]   w_credit_used;
   logic             w_grant;
   logic             w_resp;
   logic             w_push;
   logic             w_pop;
   logic             w_unused_ok;

   // Credits count both buffered words and in-flight requests, so a response
   // always has a free slot; a pop frees its credit only on the next cycle.
   assign w_credit_used = {1'b0, count_q} + {1'b0, outst_q};
   assign o_IMemReq     = !i_rst && !i_Redirect && (w_credit_used < (CNT_W+1)'(DEPTH));
   assign o_IMemAddr    = pc_q;

   assign w_grant      = o_IMemReq & i_IMemGnt;
   assign w_resp       = i_IMemRValid & (outst_q != '0);
   assign w_push       = w_resp & !i_Redirect & (drop_q == '0);
   assign o_InstrValid = (count_q != '0) & !i_Redirect;
   assign w_pop        = o_InstrValid & i_InstrReady;

   assign o_Instr   = instr_mem_q[rd_ptr_q];
   assign o_InstrPC = pc_mem_q[rd_ptr_q];
   assign o_OPCode  = o_Instr[6:0];

   assign w_unused_ok = &{1'b0, i_RedirectPC[1:0]};

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      count_d   = count_q;
      outst_d   = outst_q;
      drop_d    = drop_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;

      if (w_grant) begin
         pc_d = pc_q + 32'd4;
      end

      case ({w_grant, w_resp})
         2'b10:   outst_d = outst_q + CNT_W'(1);
         2'b01:   outst_d = outst_q - CNT_W'(1);
         default: outst_d = outst_q;
      endcase

      if (i_Redirect) begin
         pc_d      = {i_RedirectPC[31:2], 2'b00};
         resp_pc_d = {i_RedirectPC[31:2], 2'b00};
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         // outst_q already includes older stale responses, so every request
         // still in flight after this cycle becomes stale exactly once.
         drop_d    = outst_q - CNT_W'(w_resp);
      end else begin
         if (w_resp && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
         if (w_push) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         count_q   <= '0;
         outst_q   <= '0;
         drop_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         count_q   <= count_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else if (w_push) begin
         instr_mem_q[wr_ptr_q] <= i_IMemRData;
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      end
   end

endmodule

`default_nettype wire
